// File: rtl/parity_pkg.sv
// Shared types and constants for the parity stream generator/checker.
package parity_pkg;

  // Frame-level FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Parity sense selected by the mode input
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Mismatch rule for check mode: the received parity bit combined with the
  // data parity must reproduce the selected sense.
  function automatic logic parity_mismatch(input logic acc_final,
                                           input logic rx_par,
                                           input logic par_mode);
    return (acc_final ^ rx_par) != par_mode;
  endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR-reduction of one data beat.
module parity_reduce #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);

  // One-bit parity of the whole beat
  assign par = ^data;

endmodule

// File: rtl/parity_stream_gen.sv
// Frame parity generator/checker: accumulates the XOR of every beat in a
// frame and reports parity, mismatch, length and overflow once per frame.
module parity_stream_gen
  import parity_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              check_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_ovf
);

  state_t             state_reg;
  logic               acc_reg;
  logic [LEN_W-1:0]   cnt_reg;
  logic               mode_reg;
  logic               chk_reg;
  logic               out_valid_reg;
  logic               out_par_reg;
  logic               out_err_reg;
  logic [LEN_W-1:0]   out_len_reg;
  logic               out_ovf_reg;

  logic               beat_par;
  logic               accept;
  logic               first_beat;
  logic               mode_eff;
  logic               chk_eff;
  logic               acc_next;
  logic [LEN_W-1:0]   cnt_next;
  logic               hit_max;
  logic               term;

  parity_reduce #(.DATA_W(DATA_W)) u_reduce (
    .data (in_data),
    .par  (beat_par)
  );

  // Ready depends on registered state only, so upstream never sees a loop
  assign in_ready = !out_valid_reg;
  assign accept   = in_valid && in_ready;

  // On the first beat the live mode/check_en apply; afterwards the latched copy
  assign first_beat = (state_reg == IDLE);
  assign mode_eff   = first_beat ? mode     : mode_reg;
  assign chk_eff    = first_beat ? check_en : chk_reg;
  assign acc_next   = acc_reg ^ beat_par;
  assign cnt_next   = cnt_reg + LEN_W'(1);
  assign hit_max    = (cnt_next == LEN_W'(MAX_LEN));
  assign term       = in_last || hit_max;

  // Frame FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= 1'b0;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      chk_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_par_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
      out_len_reg   <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACC: begin
          if (accept) begin
            acc_reg  <= acc_next;
            cnt_reg  <= cnt_next;
            mode_reg <= mode_eff;
            chk_reg  <= chk_eff;
            if (term) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              out_par_reg   <= acc_next ^ mode_eff;
              out_len_reg   <= cnt_next;
              // A frame cut at the length limit has no trailing parity bit
              out_ovf_reg   <= !in_last;
              out_err_reg   <= chk_eff && in_last &&
                               parity_mismatch(acc_next, in_par, mode_eff);
            end else begin
              state_reg <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            acc_reg       <= 1'b0;
            cnt_reg       <= '0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          acc_reg       <= 1'b0;
          cnt_reg       <= '0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_par   = out_par_reg;
  assign out_err   = out_err_reg;
  assign out_len   = out_len_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_parity_stream_gen.sv
// Directed bench for parity_stream_gen (DATA_W=8, MAX_LEN=4).
module tb_parity_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       check_en = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_par = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_par;
  logic       out_err;
  logic [2:0] out_len;
  logic       out_ovf;

  int vectors = 0;
  int miscompares = 0;

  parity_stream_gen #(.DATA_W(8), .MAX_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .check_en  (check_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_par    (in_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_par   (out_par),
    .out_err   (out_err),
    .out_len   (out_len),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Present one beat and hold it until accepted (bounded wait)
  task automatic beat(input logic [7:0] d, input logic l, input logic p,
                      input logic m, input logic c);
    int n;
    in_data = d; in_last = l; in_par = p; mode = m; check_en = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL beat_wait: in_ready=%0b required=1 data=%02h", in_ready, d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("beat data=%02h last=%0b par=%0b mode=%0b chk=%0b", d, l, p, m, c);
  endtask

  // Accept the pending result for one cycle
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({out_valid, out_par, out_err, out_len, out_ovf} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b required 0000000", {out_valid, out_par, out_err, out_len, out_ovf});
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b required 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_even_gen();
    beat(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL even_gen_early_valid: got %0b required 0", out_valid);
    end
    beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, out_par, out_len, out_err, out_ovf} !== {1'b1, 1'b1, 3'd2, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL even_gen: got v=%0b p=%0b len=%0d e=%0b o=%0b required v=1 p=1 len=2 e=0 o=0",
               out_valid, out_par, out_len, out_err, out_ovf);
    end
    consume();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL even_gen_consume: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_odd_single();
    beat(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({out_valid, out_par, out_len, out_ovf} !== {1'b1, 1'b1, 3'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL odd_single: got v=%0b p=%0b len=%0d o=%0b required v=1 p=1 len=1 o=0",
               out_valid, out_par, out_len, out_ovf);
    end
    consume();
  endtask

  task automatic test_even_check();
    beat(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    beat(8'h10, 1'b1, 1'b1, 1'b0, 1'b1);
    vectors++;
    if ({out_valid, out_err, out_par} !== 3'b101) begin
      miscompares++; $display("FAIL check_ok: got v=%0b e=%0b p=%0b required v=1 e=0 p=1", out_valid, out_err, out_par);
    end
    consume();
    beat(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({out_valid, out_err, out_par} !== 3'b111) begin
      miscompares++; $display("FAIL check_bad: got v=%0b e=%0b p=%0b required v=1 e=1 p=1", out_valid, out_err, out_par);
    end
    consume();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, out_ovf, out_len, out_par, out_err} !== {1'b1, 1'b1, 3'd4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf: got v=%0b o=%0b len=%0d p=%0b e=%0b required v=1 o=1 len=4 p=0 e=0",
               out_valid, out_ovf, out_len, out_par, out_err);
    end
    consume();
    beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, out_ovf, out_len, out_par} !== {1'b1, 1'b0, 3'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_next: got v=%0b o=%0b len=%0d p=%0b required v=1 o=0 len=1 p=1",
               out_valid, out_ovf, out_len, out_par);
    end
    consume();
    // Cut frame in odd check mode: no trailing parity, so no error
    for (int i = 0; i < 4; i++) beat(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({out_ovf, out_par, out_err} !== 3'b110) begin
      miscompares++; $display("FAIL ovf_check: got o=%0b p=%0b e=%0b required o=1 p=1 e=0", out_ovf, out_par, out_err);
    end
    consume();
  endtask

  task automatic test_exact_max();
    for (int i = 0; i < 3; i++) beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, out_ovf, out_len, out_par} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL exact_max: got v=%0b o=%0b len=%0d p=%0b required v=1 o=0 len=4 p=0",
               out_valid, out_ovf, out_len, out_par);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    beat(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    // Offer a competing beat while the result is stalled
    in_data = 8'h01; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({out_valid, out_par, out_len, out_ovf, out_err, in_ready} !== {1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_%0d: got v=%0b p=%0b len=%0d o=%0b e=%0b rdy=%0b required v=1 p=1 len=1 o=0 e=0 rdy=0",
                 i, out_valid, out_par, out_len, out_ovf, out_err, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL stall_release: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
    // Mode/check changes after the first beat must be ignored
    beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({out_par, out_err, out_len} !== {1'b1, 1'b0, 3'd2}) begin
      miscompares++; $display("FAIL mode_latch: got p=%0b e=%0b len=%0d required p=1 e=0 len=2", out_par, out_err, out_len);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({out_valid, out_par, out_err, out_len, out_ovf} !== 7'b0) begin
      miscompares++; $display("FAIL reset_mid_outs: got %b required 0000000", {out_valid, out_par, out_err, out_len, out_ovf});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid_ready: got %0b required 1", in_ready);
    end
    beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, out_len, out_par} !== {1'b1, 3'd1, 1'b1}) begin
      miscompares++; $display("FAIL reset_mid_next: got v=%0b len=%0d p=%0b required v=1 len=1 p=1", out_valid, out_len, out_par);
    end
    consume();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_even_gen();
    test_odd_single();
    test_even_check();
    test_overflow();
    test_exact_max();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
